// File: rtl/ppu_cpu_regs_if.sv
// ppu_cpu_regs_if - CPU-side register bus of the PPU ($2000-$2007).
// master: the CPU / bus bridge; slave: ppu_cpu_regs.
interface ppu_cpu_regs_if;
  logic       ppu_reg_cs;
  logic       ppu_reg_rw;
  logic [2:0] ppu_reg_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       rdy;

  modport master (
    output ppu_reg_cs, ppu_reg_rw, ppu_reg_addr, cpu_wdata,
    input  cpu_rdata, rdy
  );

  modport slave (
    input  ppu_reg_cs, ppu_reg_rw, ppu_reg_addr, cpu_wdata,
    output cpu_rdata, rdy
  );
endinterface

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs - CPU-visible PPU register file ($2000-$2007).
// Holds PPUCTRL, PPUMASK, PPUSTATUS flags, loopy v/t/fine_x/w, the buffered
// $2007 read path, the open-bus latch and NMI generation.
// Optional define PPU_OAM_PORT_EN adds the $2003/$2004 OAM port.
//
//  state | meaning
//  IDLE  | ready for CPU accesses, rdy=1
//  RD1   | $2007 read issued, vram_re strobe high
//  RD2   | vram_rdata valid: refill buffer, advance v
module ppu_cpu_regs #(
  parameter int VADDR_W = 15
) (
  input  logic               clk,
  input  logic               reset,
  ppu_cpu_regs_if.slave      bus,
  output logic [13:0]        vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_re,
  input  logic [7:0]         vram_rdata,
  input  logic               vblank_start,
  input  logic               vblank_end,
  input  logic               sprite0_hit,
  input  logic               sprite_ovf,
  output logic [7:0]         ppu_ctrl,
  output logic [7:0]         ppu_mask,
  output logic [VADDR_W-1:0] loopy_v,
  output logic [VADDR_W-1:0] loopy_t,
  output logic [2:0]         fine_x,
`ifdef PPU_OAM_PORT_EN
  output logic [7:0]         oam_addr,
  output logic [7:0]         oam_wdata,
  output logic               oam_we,
  input  logic [7:0]         oam_rdata,
`endif
  output logic               NMI_enable
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD1  = 2'd1;
  localparam logic [1:0] S_RD2  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               cs_q;
  logic [7:0]         ctrl_q, ctrl_d, mask_q, mask_d;
  logic [VADDR_W-1:0] v_q, v_d, t_q, t_d, v_inc;
  logic [2:0]         fx_q, fx_d;
  logic               w_q, w_d;
  logic               vblank_q, vblank_d, spr0_q, spr0_d, ovf_q, ovf_d;
  logic [7:0]         latch_q, latch_d, buf_q, buf_d, rdata_q, rdata_d;
  logic               pal_q, pal_d;
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               access, status_rd;
`ifdef PPU_OAM_PORT_EN
  logic [7:0]         oam_addr_q, oam_addr_d, oam_wdata_q, oam_wdata_d;
  logic               oam_we_q, oam_we_d;
`endif

  assign access    = ~bus.ppu_reg_cs & cs_q & (state_q == S_IDLE);
  assign status_rd = access & bus.ppu_reg_rw & (bus.ppu_reg_addr == 3'd2);
  assign v_inc     = ctrl_q[2] ? VADDR_W'(32) : VADDR_W'(1);

  // Next-state: register decode, status flags, $2007 sequencing.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    mask_d   = mask_q;
    v_d      = v_q;
    t_d      = t_q;
    fx_d     = fx_q;
    w_d      = w_q;
    latch_d  = latch_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    pal_d    = pal_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
`ifdef PPU_OAM_PORT_EN
    oam_addr_d  = oam_we_q ? oam_addr_q + 8'd1 : oam_addr_q;
    oam_wdata_d = oam_wdata_q;
    oam_we_d    = 1'b0;
`endif

    // vblank_end dominates; a same-cycle $2002 read suppresses vblank_start.
    vblank_d = vblank_end ? 1'b0 : status_rd ? 1'b0 : (vblank_start | vblank_q);
    spr0_d   = vblank_end ? 1'b0 : (sprite0_hit | spr0_q);
    ovf_d    = vblank_end ? 1'b0 : (sprite_ovf | ovf_q);

    // v advances at the end of the write strobe cycle.
    if (we_q) v_d = v_q + v_inc;

    case (state_q)
      S_IDLE: begin
        if (access && bus.ppu_reg_rw && bus.ppu_reg_addr == 3'd7) begin
          state_d = S_RD1;
          pal_d   = (v_q[13:8] == 6'h3F);
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        state_d = S_IDLE;
        buf_d   = vram_rdata;
        v_d     = v_q + v_inc;
        if (pal_q) rdata_d = vram_rdata;
      end
      default: state_d = S_IDLE;
    endcase

    if (access && !bus.ppu_reg_rw) begin
      latch_d = bus.cpu_wdata;
      case (bus.ppu_reg_addr)
        3'd0: begin
          ctrl_d       = bus.cpu_wdata;
          t_d[11:10]   = bus.cpu_wdata[1:0];
        end
        3'd1: mask_d = bus.cpu_wdata;
`ifdef PPU_OAM_PORT_EN
        3'd3: oam_addr_d = bus.cpu_wdata;
        3'd4: begin
          oam_we_d    = 1'b1;
          oam_wdata_d = bus.cpu_wdata;
        end
`endif
        3'd5: begin
          if (!w_q) begin
            t_d[4:0] = bus.cpu_wdata[7:3];
            fx_d     = bus.cpu_wdata[2:0];
          end else begin
            t_d[14:12] = bus.cpu_wdata[2:0];
            t_d[9:5]   = bus.cpu_wdata[7:3];
          end
          w_d = ~w_q;
        end
        3'd6: begin
          if (!w_q) begin
            t_d[13:8] = bus.cpu_wdata[5:0];
            t_d[14]   = 1'b0;
          end else begin
            t_d[7:0] = bus.cpu_wdata;
            v_d      = {t_q[14:8], bus.cpu_wdata};
          end
          w_d = ~w_q;
        end
        3'd7: begin
          we_d    = 1'b1;
          wdata_d = bus.cpu_wdata;
        end
        default: ;
      endcase
    end else if (access) begin
      case (bus.ppu_reg_addr)
        3'd2: begin
          rdata_d = {vblank_q & ~vblank_start, spr0_q, ovf_q, latch_q[4:0]};
          w_d     = 1'b0;
        end
`ifdef PPU_OAM_PORT_EN
        3'd4: rdata_d = oam_rdata;
`endif
        3'd7:    rdata_d = buf_q;
        default: rdata_d = latch_q;
      endcase
    end
  end

  // State registers with synchronous reset; reset also aborts a $2007 read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cs_q     <= 1'b0;
      ctrl_q   <= '0;
      mask_q   <= '0;
      v_q      <= '0;
      t_q      <= '0;
      fx_q     <= '0;
      w_q      <= 1'b0;
      vblank_q <= 1'b0;
      spr0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      latch_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      pal_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
`ifdef PPU_OAM_PORT_EN
      oam_addr_q  <= '0;
      oam_wdata_q <= '0;
      oam_we_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cs_q     <= bus.ppu_reg_cs;
      ctrl_q   <= ctrl_d;
      mask_q   <= mask_d;
      v_q      <= v_d;
      t_q      <= t_d;
      fx_q     <= fx_d;
      w_q      <= w_d;
      vblank_q <= vblank_d;
      spr0_q   <= spr0_d;
      ovf_q    <= ovf_d;
      latch_q  <= latch_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      pal_q    <= pal_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
`ifdef PPU_OAM_PORT_EN
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
      oam_we_q    <= oam_we_d;
`endif
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.rdy       = (state_q == S_IDLE);
  assign vram_addr     = v_q[13:0];
  assign vram_wdata    = wdata_q;
  assign vram_we       = we_q;
  assign vram_re       = (state_q == S_RD1);
  assign ppu_ctrl      = ctrl_q;
  assign ppu_mask      = mask_q;
  assign loopy_v       = v_q;
  assign loopy_t       = t_q;
  assign fine_x        = fx_q;
  assign NMI_enable    = vblank_q & ctrl_q[7];
`ifdef PPU_OAM_PORT_EN
  assign oam_addr      = oam_addr_q;
  assign oam_wdata     = oam_wdata_q;
  assign oam_we        = oam_we_q;
`endif

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// tb_ppu_cpu_regs - scoreboard bench for ppu_cpu_regs.
// Driver updates a register-level model and queues expected read data and
// VRAM strobes; independent monitors pop and compare as the DUT responds.
module tb_ppu_cpu_regs;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ppu_cpu_regs_if bus();
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata, ppu_ctrl, ppu_mask;
  logic        vram_we, vram_re, NMI_enable;
  logic        vblank_start, vblank_end, sprite0_hit, sprite_ovf;
  logic [14:0] loopy_v, loopy_t;
  logic [2:0]  fine_x;
`ifdef PPU_OAM_PORT_EN
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata = 8'hC3;
`endif

  ppu_cpu_regs dut (
    .clk(clk), .reset(reset), .bus(bus),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_re(vram_re), .vram_rdata(vram_rdata),
    .vblank_start(vblank_start), .vblank_end(vblank_end),
    .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
    .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask), .loopy_v(loopy_v),
    .loopy_t(loopy_t), .fine_x(fine_x),
`ifdef PPU_OAM_PORT_EN
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata),
`endif
    .NMI_enable(NMI_enable)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  mem [0:16383];
  logic [7:0]  m_ctrl, m_mask, m_latch, m_buf;
  logic [14:0] m_v, m_t;
  logic [2:0]  m_fx;
  logic        m_w, m_vb, m_s0, m_ov;
  logic [7:0]  m_oam;

  logic [7:0]  rd_exp[$];
  int          rd_busy[$];
  logic [21:0] we_exp[$];
  logic [13:0] re_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] next_v(input logic [14:0] v);
    int step = m_ctrl[2] ? 32 : 1;
    return 15'((int'(v) + step) % 32768);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_latch = 0; m_buf = 0; m_v = 0; m_t = 0;
    m_fx = 0; m_w = 0; m_vb = 0; m_s0 = 0; m_ov = 0; m_oam = 0;
  endtask

  task automatic model_access(input logic rw, input logic [2:0] a, input logic [7:0] d, input bit coinc);
    logic [7:0] e;
    int busy;
    if (!rw) begin
      m_latch = d;
      case (a)
        3'd0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
        3'd1: m_mask = d;
`ifdef PPU_OAM_PORT_EN
        3'd3: m_oam = d;
        3'd4: m_oam = m_oam + 8'd1;
`endif
        3'd5: begin
          if (!m_w) begin m_t[4:0] = d[7:3]; m_fx = d[2:0]; end
          else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; end
          m_w = ~m_w;
        end
        3'd6: begin
          if (!m_w) begin m_t[13:8] = d[5:0]; m_t[14] = 1'b0; end
          else begin m_t[7:0] = d; m_v = m_t; end
          m_w = ~m_w;
        end
        3'd7: begin
          we_exp.push_back({m_v[13:0], d});
          mem[m_v[13:0]] = d;
          m_v = next_v(m_v);
        end
        default: ;
      endcase
      if (coinc) m_vb = 1'b1;
    end else begin
      busy = 0;
      case (a)
        3'd2: begin
          e = {(coinc ? 1'b0 : m_vb), m_s0, m_ov, m_latch[4:0]};
          m_vb = 1'b0;
          m_w = 1'b0;
        end
`ifdef PPU_OAM_PORT_EN
        3'd4: e = oam_rdata;
`endif
        3'd7: begin
          re_exp.push_back(m_v[13:0]);
          e = (m_v[13:8] == 6'h3F) ? mem[m_v[13:0]] : m_buf;
          m_buf = mem[m_v[13:0]];
          m_v = next_v(m_v);
          busy = 2;
        end
        default: begin
          e = m_latch;
          if (coinc) m_vb = 1'b1;
        end
      endcase
      rd_exp.push_back(e);
      rd_busy.push_back(busy);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (bus.rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_timeout", 32'(bus.rdy), 32'd1);
  endtask

  task automatic acc(input logic rw, input logic [2:0] a, input logic [7:0] d, input bit coinc = 1'b0);
    wait_rdy();
    model_access(rw, a, d, coinc);
    bus.ppu_reg_cs = 1'b0; bus.ppu_reg_rw = rw; bus.ppu_reg_addr = a; bus.cpu_wdata = d;
    vblank_start = coinc;
    @(negedge clk);
    bus.ppu_reg_cs = 1'b1; vblank_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input bit vbs, input bit vbe, input bit s0, input bit ov);
    vblank_start = vbs; vblank_end = vbe; sprite0_hit = s0; sprite_ovf = ov;
    @(negedge clk);
    vblank_start = 0; vblank_end = 0; sprite0_hit = 0; sprite_ovf = 0;
    if (vbe) begin m_vb = 0; m_s0 = 0; m_ov = 0; end
    else begin m_vb |= vbs; m_s0 |= s0; m_ov |= ov; end
  endtask

  task automatic check_state(input string tag);
    wait_rdy();
    @(negedge clk);
    @(negedge clk);
    check({tag, ".ctrl"}, 32'(ppu_ctrl), 32'(m_ctrl));
    check({tag, ".mask"}, 32'(ppu_mask), 32'(m_mask));
    check({tag, ".v"}, 32'(loopy_v), 32'(m_v));
    check({tag, ".t"}, 32'(loopy_t), 32'(m_t));
    check({tag, ".fine_x"}, 32'(fine_x), 32'(m_fx));
    check({tag, ".nmi"}, 32'(NMI_enable), 32'(m_vb & m_ctrl[7]));
`ifdef PPU_OAM_PORT_EN
    check({tag, ".oam_addr"}, 32'(oam_addr), 32'(m_oam));
`endif
  endtask

  task automatic set_v_7fff();
    acc(1, 3'd2, 8'h00);
    acc(0, 3'd6, 8'h3F);
    acc(0, 3'd5, 8'hFF);
    acc(0, 3'd5, 8'h00);
    acc(0, 3'd6, 8'hFF);
  endtask

  // VRAM responder: data for a vram_re strobe is valid the following cycle
  always @(posedge clk) vram_rdata <= vram_re ? mem[vram_addr] : 8'($urandom);

  logic cs_prev = 1'b1;
  logic rdy_neg = 1'b0;
  always @(posedge clk) cs_prev <= bus.ppu_reg_cs;
  always @(negedge clk) rdy_neg = bus.rdy;

  // read monitor: on each accepted read, wait for completion and compare
  initial begin
    int busy;
    forever begin
      @(posedge clk);
      if (!reset && !bus.ppu_reg_cs && cs_prev && rdy_neg && bus.ppu_reg_rw) begin
        @(negedge clk);
        busy = 0;
        while (bus.rdy !== 1'b1 && busy < 20) begin
          busy++;
          @(negedge clk);
        end
        if (rd_exp.size() != 0) begin
          check("cpu_rdata", 32'(bus.cpu_rdata), 32'(rd_exp.pop_front()));
          check("rdy_low_cycles", busy, rd_busy.pop_front());
        end else check("rd_queue", rd_exp.size(), 1);
      end
    end
  end

  // strobe monitor
  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      if (we_exp.size() != 0) check("vram_we_addr_data", 32'({vram_addr, vram_wdata}), 32'(we_exp.pop_front()));
      else check("we_queue", we_exp.size(), 1);
    end
    if (vram_re === 1'b1) begin
      if (re_exp.size() != 0) check("vram_re_addr", 32'(vram_addr), 32'(re_exp.pop_front()));
      else check("re_queue", re_exp.size(), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    bus.ppu_reg_cs = 1; bus.ppu_reg_rw = 1; bus.ppu_reg_addr = 0; bus.cpu_wdata = 0;
    vblank_start = 0; vblank_end = 0; sprite0_hit = 0; sprite_ovf = 0;
    reset = 1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);

    // reset state
    check("reset.rdy", 32'(bus.rdy), 32'd1);
    check("reset.nmi", 32'(NMI_enable), 32'd0);
    check("reset.rdata", 32'(bus.cpu_rdata), 32'd0);
    check_state("reset");
    acc(1, 3'd2, 8'h00);

    // $2006/$2006/$2007 write
    acc(0, 3'd6, 8'h21);
    acc(0, 3'd6, 8'h08);
    acc(0, 3'd7, 8'hAB);
    check_state("wr2007");

    // buffered reads with +32 increment
    acc(0, 3'd0, 8'h04);
    acc(0, 3'd6, 8'h20);
    acc(0, 3'd6, 8'h00);
    mem[14'h2000] = 8'h11;
    mem[14'h2020] = 8'h22;
    acc(1, 3'd7, 8'h00);
    acc(1, 3'd7, 8'h00);
    check_state("rd2007");

    // palette bypass
    acc(0, 3'd6, 8'h3F);
    acc(0, 3'd6, 8'h00);
    mem[14'h3F00] = 8'h0F;
    acc(1, 3'd7, 8'h00);
    check_state("palette");

    // scroll pair, then $2002 mid-pair resets w
    acc(0, 3'd5, 8'h7D);
    acc(0, 3'd5, 8'h5E);
    check_state("scroll");
    acc(0, 3'd5, 8'h11);
    acc(1, 3'd2, 8'h00);
    acc(0, 3'd5, 8'hC8);
    check_state("w_reset");

    // NMI generation and vblank clear on read
    acc(0, 3'd0, 8'h80);
    pulse(1, 0, 0, 0);
    check_state("nmi_on");
    acc(1, 3'd2, 8'h00);
    check_state("nmi_clr");
    acc(0, 3'd0, 8'h00);
    pulse(1, 0, 1, 1);
    acc(0, 3'd0, 8'h80);
    check_state("nmi_late_ctrl");
    acc(1, 3'd2, 8'h00);
    // vblank_start coincident with $2002 read is suppressed
    acc(1, 3'd2, 8'h00, 1'b1);
    check_state("suppress");
    // vblank_end beats same-cycle sprite flags
    pulse(0, 1, 1, 1);
    acc(1, 3'd2, 8'h00);

    // access while busy is dropped
    wait_rdy();
    model_access(1, 3'd7, 8'h00, 1'b0);
    bus.ppu_reg_cs = 0; bus.ppu_reg_rw = 1; bus.ppu_reg_addr = 3'd7;
    @(negedge clk);
    bus.ppu_reg_cs = 1;
    @(negedge clk);
    bus.ppu_reg_cs = 0; bus.ppu_reg_rw = 0; bus.ppu_reg_addr = 3'd0; bus.cpu_wdata = 8'hFF;
    @(negedge clk);
    bus.ppu_reg_cs = 1;
    check_state("dropped");
    acc(1, 3'd1, 8'h00);

    // v wrap with +1 and +32
    acc(0, 3'd0, 8'h00);
    set_v_7fff();
    acc(0, 3'd7, 8'h5A);
    check_state("wrap1");
    acc(0, 3'd0, 8'h04);
    set_v_7fff();
    acc(0, 3'd7, 8'hA5);
    check_state("wrap32");

    // reset during RD1
    wait_rdy();
    model_access(1, 3'd7, 8'h00, 1'b0);
    void'(rd_exp.pop_back()); rd_exp.push_back(8'h00);
    void'(rd_busy.pop_back()); rd_busy.push_back(1);
    bus.ppu_reg_cs = 0; bus.ppu_reg_rw = 1; bus.ppu_reg_addr = 3'd7;
    @(negedge clk);
    bus.ppu_reg_cs = 1;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_mid.rdy", 32'(bus.rdy), 32'd1);
    check("rst_mid.vram_re", 32'(vram_re), 32'd0);
    model_reset();
    check_state("rst_mid");
    acc(1, 3'd7, 8'h00);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int k = $urandom_range(0, 11);
      if (k == 0) begin
        bit vbs = 1'($urandom);
        pulse(vbs, !vbs && ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
      end else if (k == 1) acc(1, 3'd2, 8'h00, 1'b1);
      else acc(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
      if (i % 30 == 29) check_state("rand");
    end

    check_state("final");
    repeat (4) @(negedge clk);
    check("rd_q_drained", rd_exp.size(), 0);
    check("we_q_drained", we_exp.size(), 0);
    check("re_q_drained", re_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
